// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Read ports have a 1-cycle registered latency; write-to-read forwarding is optional.
module reg_file_mp #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_busy,
    input  logic                           reg_write,
    input  logic [ADDR_WIDTH-1:0]          write_reg,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_reg
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;

    logic [ADDR_WIDTH-1:0] addr_p0 [NUM_READ];
    logic [DATA_WIDTH-1:0] data_p0 [NUM_READ];
    logic                  bsy_p0  [NUM_READ];
    logic [DATA_WIDTH-1:0] data_p1 [NUM_READ];
    logic                  bsy_p1  [NUM_READ];

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Issue is applied after the clear so a same-edge producer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (reg_write)
            busy_nxt[write_reg] = 1'b0;
        if (issue_valid && !is_zero_reg(issue_reg))
            busy_nxt[issue_reg] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (reg_write && !is_zero_reg(write_reg))
                regs[write_reg] <= write_data;
            busy <= busy_nxt;
        end
    end

    // Stage p0: address decode, optional forwarding of the same-edge write and busy update
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            addr_p0[p] = read_reg[p*ADDR_WIDTH +: ADDR_WIDTH];
            data_p0[p] = regs[addr_p0[p]];
            bsy_p0[p]  = busy[addr_p0[p]];
            if (BYPASS != 0) begin
                if (reg_write && (write_reg == addr_p0[p]))
                    data_p0[p] = write_data;
                bsy_p0[p] = busy_nxt[addr_p0[p]];
            end
            if (is_zero_reg(addr_p0[p])) begin
                data_p0[p] = '0;
                bsy_p0[p]  = 1'b0;
            end
        end
    end

    // Stage p1: registered read outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_READ; p++) begin
                data_p1[p] <= '0;
                bsy_p1[p]  <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NUM_READ; p++) begin
                data_p1[p] <= data_p0[p];
                bsy_p1[p]  <= bsy_p0[p];
            end
        end
    end

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            read_data[p*DATA_WIDTH +: DATA_WIDTH] = data_p1[p];
            read_busy[p]                          = bsy_p1[p];
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: one forwarding and one non-forwarding instance
// share stimulus; a reference model queues expected outputs for a separate monitor.
module tb_reg_file_mp;

    localparam int DW    = 24;
    localparam int AW    = 2;
    localparam int NR    = 2;
    localparam int DEPTH = 4;

    logic               clock = 1'b0;
    logic               reset_n = 1'b1;
    logic [NR*AW-1:0]   read_reg = '0;
    logic               reg_write = 1'b0;
    logic [AW-1:0]      write_reg = '0;
    logic [DW-1:0]      write_data = '0;
    logic               issue_valid = 1'b0;
    logic [AW-1:0]      issue_reg = '0;

    logic [NR*DW-1:0]   rd_b, rd_n;
    logic [NR-1:0]      rb_b, rb_n;

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut_byp (
        .clock(clock), .reset_n(reset_n), .read_reg(read_reg), .read_data(rd_b), .read_busy(rb_b),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg));

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(0)) dut_nob (
        .clock(clock), .reset_n(reset_n), .read_reg(read_reg), .read_data(rd_n), .read_busy(rb_n),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg));

    always #5 clock = ~clock;

    typedef struct {
        int               due;
        logic [NR*DW-1:0] rd_b;
        logic [NR*DW-1:0] rd_n;
        logic [NR-1:0]    rb_b;
        logic [NR-1:0]    rb_n;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Monitor: pops the entry due for the edge just past and compares both instances.
    always @(negedge clock) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            for (int p = 0; p < NR; p++) begin
                check($sformatf("byp data%0d", p), rd_b[p*DW +: DW], e.rd_b[p*DW +: DW]);
                check($sformatf("nob data%0d", p), rd_n[p*DW +: DW], e.rd_n[p*DW +: DW]);
                check($sformatf("byp busy%0d", p), DW'(rb_b[p]), DW'(e.rb_b[p]));
                check($sformatf("nob busy%0d", p), DW'(rb_n[p]), DW'(e.rb_n[p]));
            end
        end
    end

    // One clock of stimulus; the expected response is derived from the model before it is updated.
    task automatic step(input bit we, input int wr, input logic [DW-1:0] wd,
                        input bit iv, input int ir, input int r0, input int r1);
        exp_t e;
        int   a;
        bit   zero;
        @(negedge clock);
        reg_write   = we;
        write_reg   = AW'(wr);
        write_data  = wd;
        issue_valid = iv;
        issue_reg   = AW'(ir);
        read_reg    = {AW'(r1), AW'(r0)};
        e.due = cyc + 1;
        for (int p = 0; p < NR; p++) begin
            a    = (p == 0) ? r0 : r1;
            zero = (a == 0);
            e.rd_n[p*DW +: DW] = zero ? '0 : m_regs[a];
            e.rd_b[p*DW +: DW] = zero ? '0 : ((we && wr == a) ? wd : m_regs[a]);
            e.rb_n[p] = m_busy[a];
            if (zero)                e.rb_b[p] = 1'b0;
            else if (iv && ir == a)  e.rb_b[p] = 1'b1;
            else if (we && wr == a)  e.rb_b[p] = 1'b0;
            else                     e.rb_b[p] = m_busy[a];
        end
        q.push_back(e);
        if (we && wr != 0) m_regs[wr] = wd;
        if (we) m_busy[wr] = 1'b0;
        if (iv && ir != 0) m_busy[ir] = 1'b1;
        @(posedge clock);
        #1;
        reg_write   = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " byp data"}, rd_b[DW-1:0], '0);
        check({tag, " byp data1"}, rd_b[2*DW-1:DW], '0);
        check({tag, " nob data"}, rd_n[DW-1:0], '0);
        check({tag, " nob data1"}, rd_n[2*DW-1:DW], '0);
        check({tag, " byp busy"}, DW'(rb_b), '0);
        check({tag, " nob busy"}, DW'(rb_n), '0);
    endtask

    // Reset pulse placed between edges; outputs must clear without a clock edge.
    task automatic reset_pulse();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async rst");
        model_clear();
        q.delete();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check_zero_outputs("por");
        reset_n = 1'b1;

        // Basic write then read on a later edge
        step(1, 1, 24'hABCDEF, 0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 1, 2);
        // Same-edge write/read of reg3: forwarded vs old contents, then a plain read
        step(1, 3, 24'h123456, 0, 0, 3, 1);
        step(0, 0, '0, 0, 0, 3, 3);
        // Zero register ignores writes and issues
        step(1, 0, 24'hFFFFFF, 0, 0, 1, 3);
        step(0, 0, '0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 1);
        step(0, 0, '0, 0, 0, 0, 0);
        // Scoreboard sequence on reg2
        step(0, 0, '0, 1, 2, 2, 1);
        step(0, 0, '0, 0, 0, 2, 2);
        step(1, 2, 24'h0F0F0F, 1, 2, 2, 0);
        step(0, 0, '0, 0, 0, 2, 1);
        step(1, 2, 24'h777777, 0, 0, 3, 1);
        step(0, 0, '0, 0, 0, 2, 2);
        // Reset mid-operation with reg1 loaded and busy
        step(1, 1, 24'h00AA55, 1, 1, 1, 2);
        step(0, 0, '0, 0, 0, 1, 1);
        reset_pulse();
        step(0, 0, '0, 0, 0, 1, 2);
        step(0, 0, '0, 0, 0, 3, 1);

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) != 0), $urandom_range(0, DEPTH-1), DW'($urandom),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, DEPTH-1),
                 $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
            if (i % 137 == 136) reset_pulse();
        end

        repeat (3) @(negedge clock);
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
